// File: rtl/vec_isa_pkg.sv
// Shared ISA definitions for the vector/scalar decode stage: opcodes, sequencer
// states, the decoded-field record and the combinational decode table.
package vec_isa_pkg;

  localparam logic [3:0] VADD = 4'd0;
  localparam logic [3:0] VDOT = 4'd1;
  localparam logic [3:0] SMUL = 4'd2;
  localparam logic [3:0] SST  = 4'd3;
  localparam logic [3:0] VLD  = 4'd4;
  localparam logic [3:0] VST  = 4'd5;
  localparam logic [3:0] SLL  = 4'd6;
  localparam logic [3:0] SLH  = 4'd7;
  localparam logic [3:0] J    = 4'd8;
  localparam logic [3:0] NOP  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_MEM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [3:0] functype;
    logic [2:0] dst;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm;
    logic [5:0] off;
    logic       v_en;
    logic       s_en;
    logic       is_mem;
    logic       is_store;
    logic       single;
    logic       illegal;
  } dec_t;

  // Memory ops carry the base register in src1 and, for stores, the data
  // register in src2 so the latched record stays self-describing.
  function automatic dec_t decode_instr(input logic [15:0] w);
    dec_t d;
    d          = '0;
    d.functype = w[15:12];
    case (w[15:12])
      VADD: begin
        d.dst  = w[11:9];
        d.src1 = w[8:6];
        d.src2 = w[5:3];
        d.v_en = 1'b1;
      end
      VDOT, SMUL: begin
        d.dst  = w[11:9];
        d.src1 = w[8:6];
        d.src2 = w[5:3];
      end
      VLD: begin
        d.dst    = w[11:9];
        d.src1   = w[8:6];
        d.off    = w[5:0];
        d.is_mem = 1'b1;
      end
      VST: begin
        d.src2     = w[11:9];
        d.src1     = w[8:6];
        d.off      = w[5:0];
        d.is_mem   = 1'b1;
        d.is_store = 1'b1;
      end
      SST: begin
        d.src2     = w[11:9];
        d.src1     = w[8:6];
        d.off      = w[5:0];
        d.is_mem   = 1'b1;
        d.is_store = 1'b1;
        d.single   = 1'b1;
      end
      SLL, SLH: begin
        d.dst  = w[11:9];
        d.src1 = w[11:9];
        d.imm  = w[7:0];
        d.s_en = 1'b1;
      end
      J: begin
        d.imm = w[7:0];
      end
      NOP: begin
        d.functype = w[15:12];
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ld_delay_pipe.sv
// Fixed-latency valid/index shift register that times load write-backs
// relative to their memory grants; async reset drops anything in flight.
module ld_delay_pipe #(
  parameter int LD_LAT = 1,
  parameter int IW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);

  logic [LD_LAT-1:0] vld_q;
  logic [IW-1:0]     idx_q [LD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < LD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LD_LAT-1];
  assign out_idx   = idx_q[LD_LAT-1];

endmodule

// File: rtl/vec_decode_seq.sv
// Decode-and-sequence stage: registers decoded instruction fields, pulses
// single-cycle ops and walks memory ops element by element.
//
//   state    | meaning
//   ST_IDLE  | ready for an instruction
//   ST_ISSUE | decoded non-memory op presented for one cycle
//   ST_MEM   | requesting one element per grant
//   ST_DRAIN | all loads granted, waiting for the last write-back
//   ST_DONE  | one-cycle completion pulse
module vec_decode_seq
  import vec_isa_pkg::*;
#(
  parameter int VLEN   = 16,
  parameter int ADDR_W = 16,
  parameter int LD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  input  logic [15:0]             instr,
  output logic                    instr_ready,
  output logic [2:0]              rf_raddr,
  input  logic [ADDR_W-1:0]       rf_rdata,
  output logic                    op_valid,
  output logic [3:0]              functype,
  output logic [2:0]              dst_addr,
  output logic [2:0]              src1_addr,
  output logic [2:0]              src2_addr,
  output logic [7:0]              immediate,
  output logic                    v_en,
  output logic                    s_en,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_gnt,
  output logic [$clog2(VLEN)-1:0] elem_idx,
  output logic                    vwr_en,
  output logic [2:0]              vwr_addr,
  output logic [$clog2(VLEN)-1:0] vwr_idx,
  output logic                    done,
  output logic                    illegal
);

  localparam int IW = $clog2(VLEN);

  state_t            state_q, state_d;
  dec_t              dec_in, dec_q;
  logic [ADDR_W-1:0] base_q;
  logic [IW-1:0]     elem_q;
  logic              accept;
  logic              in_mem;
  logic              last_elem;
  logic              ld_grant;
  logic              wb_valid;
  logic [IW-1:0]     wb_idx;

  assign dec_in    = decode_instr(instr);
  assign accept    = (state_q == ST_IDLE) && instr_valid;
  assign in_mem    = (state_q == ST_MEM) && dec_q.is_mem;
  assign last_elem = dec_q.single || (elem_q == IW'(VLEN - 1));
  assign ld_grant  = in_mem && mem_gnt && !dec_q.is_store;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = dec_in.is_mem ? ST_MEM : ST_ISSUE;
      ST_ISSUE: state_d = ST_IDLE;
      ST_MEM: begin
        if (mem_gnt && last_elem) state_d = dec_q.is_store ? ST_DONE : ST_DRAIN;
      end
      // Loads retire in element order, so the last write-back is index VLEN-1.
      ST_DRAIN: if (wb_valid && (wb_idx == IW'(VLEN - 1))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dec_q   <= '0;
      base_q  <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dec_q  <= dec_in;
        base_q <= rf_rdata;
        elem_q <= '0;
      end else if (in_mem && mem_gnt) begin
        elem_q <= last_elem ? '0 : elem_q + 1'b1;
      end
    end
  end

  ld_delay_pipe #(
    .LD_LAT (LD_LAT),
    .IW     (IW)
  ) u_ld_delay_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ld_grant),
    .in_idx    (elem_q),
    .out_valid (wb_valid),
    .out_idx   (wb_idx)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign rf_raddr    = instr[8:6];
  assign op_valid    = (state_q == ST_ISSUE);
  assign functype    = dec_q.functype;
  assign dst_addr    = dec_q.dst;
  assign src1_addr   = dec_q.src1;
  assign src2_addr   = dec_q.src2;
  assign immediate   = dec_q.imm;
  assign v_en        = op_valid && dec_q.v_en;
  assign s_en        = op_valid && dec_q.s_en;
  assign illegal     = op_valid && dec_q.illegal;
  assign mem_req     = in_mem;
  assign mem_we      = in_mem && dec_q.is_store;
  assign mem_addr    = in_mem ? base_q + {{(ADDR_W-6){dec_q.off[5]}}, dec_q.off} + ADDR_W'(elem_q)
                              : '0;
  assign elem_idx    = elem_q;
  assign vwr_en      = wb_valid;
  assign vwr_idx     = wb_idx;
  assign vwr_addr    = dec_q.dst;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_vec_decode_seq.sv
// Scoreboard bench for vec_decode_seq: one instance with LD_LAT=1 for decode and
// memory sequencing, one with LD_LAT=3 for the mid-load reset scenario.
module tb_vec_decode_seq;

  localparam int LAT1 = 1;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [3:0]  idx;
    logic        last;
    logic        ld;
  } mem_exp_t;

  typedef struct packed {
    logic [3:0] idx;
    logic [2:0] dst;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_valid3;
  logic [15:0] instr;
  logic [15:0] rf_rdata;
  logic        mem_gnt;

  logic        instr_ready, op_valid, v_en, s_en, mem_req, mem_we, vwr_en, done, illegal;
  logic [2:0]  rf_raddr, dst_addr, src1_addr, src2_addr, vwr_addr;
  logic [3:0]  functype, elem_idx, vwr_idx;
  logic [7:0]  immediate;
  logic [15:0] mem_addr;

  logic        instr_ready3, op_valid3, v_en3, s_en3, mem_req3, mem_we3, vwr_en3, done3, illegal3;
  logic [2:0]  rf_raddr3, dst3, src1_3, src2_3, vwr_addr3;
  logic [3:0]  functype3, elem_idx3, vwr_idx3;
  logic [7:0]  imm3;
  logic [15:0] mem_addr3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int stall_from = 0;
  int stall_to   = 0;
  int exp_done_cyc = -1;
  int done_at = -1;
  bit done_seen = 1'b0;
  int grants = 0;

  logic [31:0] exp_op [$];
  mem_exp_t    exp_mem [$];
  wb_exp_t     exp_wb [$];
  int          wb_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_gnt = !((cyc >= stall_from) && (cyc < stall_to));

  vec_decode_seq #(.VLEN(16), .ADDR_W(16), .LD_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .op_valid(op_valid), .functype(functype), .dst_addr(dst_addr),
    .src1_addr(src1_addr), .src2_addr(src2_addr), .immediate(immediate),
    .v_en(v_en), .s_en(s_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .elem_idx(elem_idx),
    .vwr_en(vwr_en), .vwr_addr(vwr_addr), .vwr_idx(vwr_idx), .done(done),
    .illegal(illegal)
  );

  vec_decode_seq #(.VLEN(16), .ADDR_W(16), .LD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid3), .instr(instr),
    .instr_ready(instr_ready3), .rf_raddr(rf_raddr3), .rf_rdata(rf_rdata),
    .op_valid(op_valid3), .functype(functype3), .dst_addr(dst3),
    .src1_addr(src1_3), .src2_addr(src2_3), .immediate(imm3),
    .v_en(v_en3), .s_en(s_en3), .mem_req(mem_req3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_gnt(mem_gnt), .elem_idx(elem_idx3),
    .vwr_en(vwr_en3), .vwr_addr(vwr_addr3), .vwr_idx(vwr_idx3), .done(done3),
    .illegal(illegal3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected decode of a non-memory op, packed as the monitor packs DUT outputs.
  function automatic logic [31:0] model_op(input logic [15:0] w);
    logic [3:0] op;
    logic [2:0] d, a, b;
    logic [7:0] im;
    logic       ve, se, il;
    op = w[15:12];
    d = 3'd0; a = 3'd0; b = 3'd0; im = 8'd0; ve = 1'b0; se = 1'b0; il = 1'b0;
    if (op <= 4'd2) begin
      d = w[11:9]; a = w[8:6]; b = w[5:3]; ve = (op == 4'd0);
    end else if (op == 4'd6 || op == 4'd7) begin
      d = w[11:9]; a = w[11:9]; im = w[7:0]; se = 1'b1;
    end else if (op == 4'd8) begin
      im = w[7:0];
    end else if (op >= 4'd9 && op <= 4'd14) begin
      il = 1'b1;
    end
    return {8'h00, op, d, a, b, im, ve, se, il};
  endfunction

  logic [31:0] mon_op;
  mem_exp_t    mon_m;
  wb_exp_t     mon_w;
  int          mon_c;

  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid) begin
        if (exp_op.size() == 0) chk("op_unexpected", 32'd1, 32'd0);
        else begin
          mon_op = exp_op.pop_front();
          chk("op_fields", {8'h00, functype, dst_addr, src1_addr, src2_addr, immediate,
                            v_en, s_en, illegal}, mon_op);
        end
      end
      if (mem_req) begin
        if (exp_mem.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          mon_m = exp_mem[0];
          if (mem_gnt) begin
            void'(exp_mem.pop_front());
            grants++;
            chk("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
            chk("mem_we", 32'(mem_we), 32'(mon_m.we));
            chk("elem_idx", 32'(elem_idx), 32'(mon_m.idx));
            if (mon_m.ld) wb_cyc.push_back(cyc + LAT1);
            if (mon_m.last) exp_done_cyc = mon_m.ld ? cyc + LAT1 + 1 : cyc + 1;
          end else begin
            chk("stall_addr_hold", 32'(mem_addr), 32'(mon_m.addr));
            chk("stall_idx_hold", 32'(elem_idx), 32'(mon_m.idx));
          end
        end
      end
      if (vwr_en) begin
        if (exp_wb.size() == 0 || wb_cyc.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          mon_w = exp_wb.pop_front();
          mon_c = wb_cyc.pop_front();
          chk("vwr_idx", 32'(vwr_idx), 32'(mon_w.idx));
          chk("vwr_addr", 32'(vwr_addr), 32'(mon_w.dst));
          chk("vwr_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_at   = cyc;
        chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
      end
    end
  end

  // Caller is at a negedge; returns one negedge after the accept edge.
  task automatic send(input logic [15:0] w, input logic [15:0] rd, input bit to3, output int t);
    instr    = w;
    rf_rdata = rd;
    if (to3) begin
      instr_valid3 = 1'b1;
      chk("ready_at_send3", 32'(instr_ready3), 32'd1);
    end else begin
      instr_valid = 1'b1;
      chk("ready_at_send", 32'(instr_ready), 32'd1);
    end
    t = cyc;
    @(negedge clk);
    instr_valid  = 1'b0;
    instr_valid3 = 1'b0;
  endtask

  task automatic mem_op(input logic [15:0] w, input logic [15:0] rd, input int stall_off,
                        input int stall_len, output int t);
    logic [15:0] off16;
    bit          ld;
    int          n;
    mem_exp_t    e;
    wb_exp_t     wb;
    off16 = {{10{w[5]}}, w[5:0]};
    ld    = (w[15:12] == 4'd4);
    n     = (w[15:12] == 4'd3) ? 1 : 16;
    for (int i = 0; i < n; i++) begin
      e.addr = rd + off16 + 16'(i);
      e.we   = !ld;
      e.idx  = 4'(i);
      e.last = (i == n - 1);
      e.ld   = ld;
      exp_mem.push_back(e);
      if (ld) begin
        wb.idx = 4'(i);
        wb.dst = w[11:9];
        exp_wb.push_back(wb);
      end
    end
    exp_done_cyc = -1;
    done_seen    = 1'b0;
    grants       = 0;
    if (stall_len > 0) begin
      stall_from = cyc + stall_off;
      stall_to   = cyc + stall_off + stall_len;
    end
    send(w, rd, 1'b0, t);
    for (int k = 0; k < 200 && !done_seen; k++) @(negedge clk);
    chk("mem_done_seen", 32'(done_seen), 32'd1);
    chk("mem_grants", 32'(grants), 32'(n));
    chk("mem_q_left", 32'(exp_mem.size()), 32'd0);
    chk("wb_q_left", 32'(exp_wb.size()), 32'd0);
    stall_from = 0;
    stall_to   = 0;
    @(negedge clk);
  endtask

  logic [15:0] op_tab [5] = '{16'h9123, 16'h8ABC, 16'hF123, 16'h1AD0, 16'h75C3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cnt;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_valid3 = 1'b0;
    instr = 16'h01C0;
    rf_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_raddr", 32'(rf_raddr), 32'd7);
    chk("rst_outs", {24'h0, op_valid, mem_req, mem_we, done, vwr_en, illegal, v_en, s_en}, 32'd0);
    chk("rst_fields", {functype, dst_addr, src1_addr, src2_addr, immediate}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // VADD then SLL accepted two cycles later
    exp_op.push_back(model_op(16'h0AD0));
    send(16'h0AD0, 16'h0000, 1'b0, t);
    chk("vadd_ready_low", 32'(instr_ready), 32'd0);
    chk("vadd_op_valid", 32'(op_valid), 32'd1);
    chk("vadd_regs", {v_en, dst_addr, src1_addr, src2_addr}, {22'h0, 1'b1, 3'd5, 3'd3, 3'd2});
    @(negedge clk);
    chk("vadd_ready_back", 32'(instr_ready), 32'd1);
    chk("vadd_pulse_end", 32'(op_valid), 32'd0);
    exp_op.push_back(model_op(16'h645A));
    send(16'h645A, 16'h0000, 1'b0, t);
    chk("sll_op", {op_valid, s_en, v_en, dst_addr, src1_addr, immediate},
        {15'h0, 1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 8'h5A});
    @(negedge clk);

    foreach (op_tab[i]) begin
      exp_op.push_back(model_op(op_tab[i]));
      send(op_tab[i], 16'h0000, 1'b0, t);
      @(negedge clk);
    end
    chk("op_q_empty", 32'(exp_op.size()), 32'd0);

    // VLD 0x42BE from base 0x0100, continuous grant
    mem_op(16'h42BE, 16'h0100, 0, 0, t);
    chk("vld_done_abs", 32'(done_at), 32'(t + 18));

    // VST with grant withheld for 3 cycles at element 4
    mem_op(16'h5A40, 16'h2000, 5, 3, t);
    chk("vst_done_abs", 32'(done_at), 32'(t + 20));

    // VST continuous grant
    mem_op(16'h5A40, 16'h3000, 0, 0, t);
    chk("vst_fast_done", 32'(done_at), 32'(t + 17));

    // SST wrapping 0xFFFF + 1
    mem_op(16'h3001, 16'hFFFF, 0, 0, t);
    chk("sst_done_abs", 32'(done_at), 32'(t + 2));

    // LD_LAT=3 instance: reset during element 7 of a VLD
    send(16'h42BE, 16'h0100, 1'b1, t);
    repeat (7) @(negedge clk);
    chk("ld3_wb_en", 32'(vwr_en3), 32'd1);
    chk("ld3_wb_idx", 32'(vwr_idx3), 32'd4);
    chk("ld3_elem7", {mem_req3, elem_idx3, mem_addr3}, {11'h0, 1'b1, 4'd7, 16'h0105});
    rst_n = 1'b0;
    #1;
    chk("ld3_rst_ready", 32'(instr_ready3), 32'd1);
    chk("ld3_rst_outs", {24'h0, mem_req3, vwr_en3, done3, op_valid3, elem_idx3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (vwr_en3) cnt++;
    end
    chk("ld3_no_wb_after_rst", 32'(cnt), 32'd0);
    send(16'h0AD0, 16'h0000, 1'b1, t);
    chk("ld3_next_op", {op_valid3, v_en3, dst3, src1_3, src2_3},
        {21'h0, 1'b1, 1'b1, 3'd5, 3'd3, 3'd2});
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_decode_seq.md
# vec_decode_seq

Parametrised decode-and-sequence stage for the vector/scalar core. It accepts 16-bit instructions over a valid/ready handshake and registers the decoded fields. Single-cycle operations issue to the execute units. Memory operations (VLD/VST/SST) run as a multi-element sequence: the block generates per-element addresses, handshakes each element with data memory, and delays load write-backs by a configurable latency. It sits between instruction fetch and the register files/data memory, replacing the purely combinational decoder and its fixed cycle counts.

## Interface
- VLEN, 16: elements per vector op (>=2).
- ADDR_W, 16: data-memory address width.
- LD_LAT, 1: cycles from memory grant to load data valid (>=1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  fetch presents instr.
- instr  in  16  instruction word.
- instr_ready  out  1  block can accept an instruction.
- rf_raddr  out  3  combinational `instr[8:6]`, the base-register read address.
- rf_rdata  in  ADDR_W  base-register value, sampled at accept.
- op_valid  out  1  one-cycle pulse: decoded non-memory op is valid.
- functype  out  4  latched opcode.
- dst_addr, src1_addr, src2_addr  out  3 each  latched register fields.
- immediate  out  8  latched `instr[7:0]` (SLL/SLH/J only, else 0).
- v_en, s_en  out  1 each  write enables, qualified by op_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a store.
- mem_addr  out  ADDR_W  element address.
- mem_gnt  in  1  request accepted this cycle.
- elem_idx  out  $clog2(VLEN)  current element; this is the VST source element.
- vwr_en  out  1  VLD element write-back.
- vwr_addr  out  3  VLD destination register.
- vwr_idx  out  $clog2(VLEN)  VLD element written.
- done  out  1  one-cycle pulse: memory op complete.
- illegal  out  1  one-cycle pulse alongside op_valid for opcodes 9–14.

## Operation
- Field map per opcode:
  - VADD: dst = [11:9], src1 = [8:6], src2 = [5:3], v_en.
  - VLD: dst = [11:9], base = [8:6], off = [5:0].
  - VST/SST: data = [11:9], base = [8:6], off = [5:0].
  - SLL/SLH: dst = src1 = [11:9], imm = [7:0], s_en.
  - J: imm only.
  - VDOT/SMUL: VADD field layout, no enables in this stage.
  - NOP and illegal opcodes: all fields 0.
- States: IDLE, ISSUE, MEM, DRAIN, DONE.
- IDLE: instr_ready = 1. On instr_valid & instr_ready, latch all fields and base = rf_rdata.
  - Non-memory op → ISSUE.
  - VLD/VST/SST → MEM with elem_idx = 0.
- ISSUE: op_valid = 1 for one cycle, then → IDLE.
- MEM: mem_req = 1 and mem_addr = base + sext(off) + elem_idx, computed modulo 2^ADDR_W. mem_we = 1 for VST/SST.
  - On mem_gnt, elem_idx increments.
  - Without mem_gnt, mem_req, mem_addr and elem_idx hold.
  - SST issues one element. VST/VLD issue VLEN elements.
  - After the final grant: → DRAIN for VLD, → DONE for stores.
- Load pipeline: an LD_LAT-deep shift register carries (valid, idx). vwr_en/vwr_idx appear exactly LD_LAT cycles after each VLD grant. vwr_addr = latched dst.
- DRAIN: wait until the last write-back has been emitted, then → DONE.
- DONE: done = 1 for one cycle, then → IDLE.
- instr_ready = 0 in every state except IDLE.

## Timing
- Accept at cycle T:
  - op_valid at T+1; next accept possible at T+2.
  - First mem_req at T+1.
- Store with last grant at G: done at G+1.
- Load with last grant at G: last vwr_en at G+LD_LAT, done at G+LD_LAT+1.
- Back-to-back grants give one element per cycle: VST of VLEN=16 with continuous grant → done at T+17.
- Reset (async, any state, including mid-MEM or mid-DRAIN):
  - State returns to IDLE; the load pipeline is cleared.
  - All outputs are 0 except instr_ready = 1 and rf_raddr, which follows instr.
  - In-flight load write-backs are dropped.
- Address computation wraps with no error flag.

## Structure
- Package `vec_isa_pkg` holds:
  - opcode localparams (VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, J=8, NOP=15);
  - the state enum;
  - a typedef for the decoded-field struct.
- One sub-module, `ld_delay_pipe`: LD_LAT-deep valid/index shift register with async clear.
- The decode table is a combinational function in the package. The FSM and element counter live in the top module.

## Test plan
- VADD 0x0AD0 accepted → next cycle: op_valid = 1, v_en = 1, dst = 5, src1 = 3, src2 = 2; instr_ready = 0 for that cycle only.
- SLL 0x645A → op_valid with s_en = 1, dst = src1 = 2, immediate = 0x5A. Opcode 0x9xxx → op_valid with illegal = 1 and no enables.
- VLD 0x42BE, rf_rdata = 0x0100, mem_gnt tied 1, LD_LAT = 1:
  - mem_addr runs 0x00FE through 0x010D;
  - vwr_en for idx 0–15 with vwr_addr = 1;
  - done 1 cycle after the last vwr_en.
- VST with mem_gnt low for 3 cycles at elem 4 → mem_addr and elem_idx hold during the stall; 16 total grants; done at last grant + 1.
- SST with base 0xFFFF, off = +1 → single request at 0x0000, mem_we = 1, done the next cycle.
- rst_n low during VLD elem 7 with LD_LAT = 3 → no vwr_en after reset, instr_ready = 1 immediately, and the next instruction decodes normally.
